// File: rtl/frontend_stream_tx.sv
// Framed word transmitter: input FIFO feeding a registered valid/ready output stage,
// sequenced into NUM_FRAMES frames of FRAME_LEN words with an idle gap between frames.
module frontend_stream_tx #(
    parameter int DATA_W     = 32,
    parameter int FRAME_LEN  = 64,
    parameter int NUM_FRAMES = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tvalid_out,
    output logic [DATA_W-1:0] tdata_out,
    output logic              tlast_out,
    input  logic              tready_out,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_idx
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int LOAD_W   = $clog2(FRAME_LEN + 1);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_t            state_q, state_d;
    logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0]       frame_idx_q, frame_idx_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              push, pop, accept;

    assign in_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign accept   = tvalid_q && tready_out;
    // The last word of a frame is never overlapped with a new load, which yields the inter-frame bubble.
    assign pop      = (state_q == S_SEND) && (count_q != '0)
                      && (!tvalid_q || (accept && !tlast_q))
                      && (load_cnt_q < LOAD_W'(FRAME_LEN));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_idx_d = frame_idx_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;

        if (pop) begin
            tdata_d    = mem_q[rd_ptr_q];
            tvalid_d   = 1'b1;
            tlast_d    = (load_cnt_q == LOAD_W'(FRAME_LEN - 1));
            load_cnt_d = load_cnt_q + LOAD_W'(1);
        end else if (accept) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_SEND;
                    frame_idx_d = '0;
                    load_cnt_d  = '0;
                end
            end
            S_SEND: begin
                if (accept && tlast_q) begin
                    if (frame_idx_q == 16'(NUM_FRAMES - 1)) begin
                        state_d = S_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        frame_idx_d = frame_idx_q + 16'd1;
                        load_cnt_d  = '0;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    state_d     = S_SEND;
                    frame_idx_d = frame_idx_q + 16'd1;
                    load_cnt_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_SEND) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            load_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            frame_idx_q <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_idx_q <= frame_idx_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tvalid_out = tvalid_q;
    assign tdata_out  = tdata_q;
    assign tlast_out  = tlast_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_idx  = frame_idx_q;

endmodule

// File: tb/tb_frontend_stream_tx.sv
// Bench for frontend_stream_tx: a short single-frame instance driven from a vector table,
// and a 3x64-word instance checked against a queue-based stream model.
module tb_frontend_stream_tx;

    localparam int FL_B  = 64;
    localparam int NF_B  = 3;
    localparam int GAP_B = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_start, a_in_valid, a_in_ready, a_tvalid, a_tlast, a_tready, a_busy, a_done;
    logic [31:0] a_in_data, a_tdata;
    logic [15:0] a_frame_idx;

    logic        b_start, b_in_valid, b_in_ready, b_tvalid, b_tlast, b_tready, b_busy, b_done;
    logic [31:0] b_in_data, b_tdata;
    logic [15:0] b_frame_idx;

    frontend_stream_tx #(.DATA_W(32), .FRAME_LEN(4), .NUM_FRAMES(1), .FIFO_DEPTH(16), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .tvalid_out(a_tvalid), .tdata_out(a_tdata), .tlast_out(a_tlast),
        .tready_out(a_tready), .busy(a_busy), .done(a_done), .frame_idx(a_frame_idx));

    frontend_stream_tx #(.DATA_W(32), .FRAME_LEN(FL_B), .NUM_FRAMES(NF_B), .FIFO_DEPTH(16), .GAP_CYCLES(GAP_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .tvalid_out(b_tvalid), .tdata_out(b_tdata), .tlast_out(b_tlast),
        .tready_out(b_tready), .busy(b_busy), .done(b_done), .frame_idx(b_frame_idx));

    int tests = 0, fails = 0;
    int mon_tests = 0, mon_fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mchk(input string name, input logic [63:0] act, input logic [63:0] exp);
        mon_tests++;
        if (act !== exp) begin
            mon_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stream model for instance B: words in push order, frames of FL_B beats, idle gap between frames.
    logic [31:0] model_q[$];
    int          beats_run = 0;
    int          idle_cnt = 0;
    bit          idle_active = 0, exp_done = 0, gap_strict = 0;
    bit          p_valid = 0, p_ready = 0, p_last = 0;
    logic [31:0] p_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
            beats_run   = 0;
            idle_active = 0;
            exp_done    = 0;
            p_valid     = 0;
            p_ready     = 0;
        end else begin
            if (exp_done) begin
                mchk("done_after_final_tlast", {b_done, b_busy, b_tvalid}, 3'b100);
                exp_done = 0;
            end
            if (p_valid && !p_ready)
                mchk("stall_hold", {b_tvalid, b_tlast, b_tdata}, {1'b1, p_last, p_data});
            if (idle_active && b_tvalid) begin
                if (gap_strict) mchk("gap_idle_cycles", idle_cnt, GAP_B + 1);
                else            mchk("gap_idle_min", idle_cnt >= GAP_B + 1, 1);
                idle_active = 0;
            end else if (idle_active) begin
                idle_cnt++;
            end
            if (b_tvalid && b_tready) begin
                logic [31:0] exp_w;
                bit          exp_l;
                exp_w = 32'hDEAD_BEEF;
                if (model_q.size() == 0) mchk("beat_without_word", 1, 0);
                else exp_w = model_q.pop_front();
                exp_l = ((beats_run % FL_B) == FL_B - 1);
                mchk("beat_data", b_tdata, exp_w);
                mchk("beat_tlast", b_tlast, exp_l);
                mchk("beat_frame_idx", b_frame_idx, beats_run / FL_B);
                beats_run++;
                if (exp_l) begin
                    if (beats_run == FL_B * NF_B) exp_done = 1;
                    else begin
                        idle_active = 1;
                        idle_cnt    = 0;
                    end
                end
            end
            if (b_start && !b_busy) begin
                beats_run   = 0;
                idle_active = 0;
            end
            if (b_in_valid && b_in_ready) model_q.push_back(b_in_data);
            p_valid = b_tvalid;
            p_ready = b_tready;
            p_last  = b_tlast;
            p_data  = b_tdata;
        end
    end

    task automatic run_random(input int budget, input string tag);
        int n = 0;
        while (!b_done && n < budget) begin
            b_tready   = $urandom_range(0, 1);
            b_in_valid = ($urandom % 3) != 0;
            b_in_data  = $urandom;
            b_start    = b_busy && (($urandom % 8) == 0);
            tick;
            n++;
        end
        b_start    = 0;
        b_in_valid = 0;
        b_tready   = 0;
        chk({"run_done_", tag}, b_done, 1);
    endtask

    typedef struct {
        logic        start;
        logic        tready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t        tbl[9];
    logic [31:0] words[4];

    initial begin
        int n;
        int pushes;
        int full_at;

        words = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h3F800000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h3F800000, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h40000000, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h40400000, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h40800000, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h40800000, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};

        rst_n = 0;
        a_start = 0; a_in_valid = 0; a_in_data = 0; a_tready = 0;
        b_start = 0; b_in_valid = 0; b_in_data = 0; b_tready = 0;
        #2;
        chk("a_reset_outputs", {a_tvalid, a_tlast, a_busy, a_done, a_in_ready}, 5'b00001);
        chk("a_reset_data", {a_tdata, a_frame_idx}, 48'h0);
        chk("b_reset_outputs", {b_tvalid, b_tlast, b_busy, b_done, b_in_ready}, 5'b00001);
        chk("b_reset_data", {b_tdata, b_frame_idx}, 48'h0);
        tick;
        #3 rst_n = 1;
        tick;

        // Single frame from a preloaded FIFO, driven row by row.
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1;
            a_in_data  = words[i];
            tick;
        end
        a_in_valid = 0;
        for (int i = 0; i < 9; i++) begin
            a_start  = tbl[i].start;
            a_tready = tbl[i].tready;
            tick;
            a_start = 0;
            chk($sformatf("a_row%0d_valid", i), a_tvalid, tbl[i].exp_valid);
            if (tbl[i].exp_valid)
                chk($sformatf("a_row%0d_data_last", i), {a_tdata, a_tlast}, {tbl[i].exp_data, tbl[i].exp_last});
            chk($sformatf("a_row%0d_busy_done", i), {a_busy, a_done}, {tbl[i].exp_busy, tbl[i].exp_done});
            chk($sformatf("a_row%0d_frame_idx", i), a_frame_idx, 16'd0);
        end
        a_tready = 0;

        // FIFO full: empty FIFO, consumer stalled, 20 push attempts.
        b_tready = 0;
        b_start  = 1;
        tick;
        b_start = 0;
        pushes  = 0;
        full_at = -1;
        for (int i = 0; i < 20; i++) begin
            b_in_valid = 1;
            b_in_data  = $urandom;
            if (b_in_ready) pushes++;
            tick;
            if (!b_in_ready && full_at < 0) full_at = pushes;
        end
        b_in_valid = 0;
        chk("full_after_pushes", full_at, 17);
        chk("full_total_pushes", pushes, 17);
        chk("full_in_ready", b_in_ready, 0);

        // Backpressure with random ready, sparse input and start pulses while busy.
        gap_strict = 0;
        run_random(20000, "backpressure");

        // Three frames at full rate; start held high whenever busy (SEND and GAP).
        gap_strict = 1;
        b_tready   = 1;
        b_in_valid = 1;
        b_in_data  = $urandom;
        b_start    = 1;
        tick;
        b_start = 0;
        chk("multi_frame_idx_start", b_frame_idx, 0);
        n = 0;
        while (!b_done && n < 5000) begin
            b_in_data = $urandom;
            b_start   = b_busy;
            tick;
            n++;
        end
        b_start    = 0;
        b_in_valid = 0;
        chk("multi_run_done", {b_done, b_busy}, 2'b10);
        chk("multi_frame_idx_end", b_frame_idx, NF_B - 1);

        // Reset in the middle of frame 0.
        gap_strict = 0;
        b_in_valid = 1;
        b_in_data  = $urandom;
        b_start    = 1;
        tick;
        b_start = 0;
        n = 0;
        while (beats_run < 10 && n < 500) begin
            b_in_data = $urandom;
            tick;
            n++;
        end
        chk("reach_word10", beats_run >= 10, 1);
        b_in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("midrst_outputs", {b_tvalid, b_tlast, b_busy, b_done, b_in_ready}, 5'b00001);
        chk("midrst_data", {b_tdata, b_frame_idx}, 48'h0);
        tick;
        tick;
        #3 rst_n = 1;
        tick;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1;
            b_in_data  = words[i];
            tick;
        end
        b_in_valid = 0;
        b_start    = 1;
        tick;
        b_start = 0;
        chk("post_rst_not_yet_valid", b_tvalid, 0);
        tick;
        chk("post_rst_first_word", {b_tvalid, b_tdata, b_frame_idx}, {1'b1, words[0], 16'd0});
        run_random(20000, "after_reset");

        tick;
        tick;
        tests += mon_tests;
        fails += mon_fails;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
